fpmul_arbiter: RTL and testbench
================================

FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter TIMEOUT, default 64, maximum WAIT cycles before abort; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0, req1  input  1 each  level request from requester 0/1; held with its operands until the matching gnt.
REQ-006 a0, b0, a1, b1  input  WIDTH each  operands of requester 0/1.
REQ-007 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands already captured when it is seen.
REQ-008 done0, done1  output  1 each  one-cycle completion pulse to the owning requester.
REQ-009 res_p  output  WIDTH  captured product.
REQ-010 res_flags  output  6  captured {OF,UF,NANF,INFF,DNF,ZF}.
REQ-011 res_err  output  1  high when the last operation timed out.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 mul_start  output  1  start pulse to the multiplier.
REQ-014 mul_a, mul_b  output  WIDTH each  latched operands driven to the multiplier.
REQ-015 mul_done  input  1  multiplier completion.
REQ-016 mul_p  input  WIDTH  multiplier product.
REQ-017 mul_flags  input  6  multiplier flags, same order as res_flags.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP; all outputs decoded from registered state/owner/result registers, no combinational input-to-output paths.
REQ-019 IDLE, no req: stay IDLE.
REQ-020 IDLE, exactly one req high: owner <= that requester; mul_a/mul_b <= its operands; next state ISSUE.
REQ-021 IDLE, both req high: owner <= requester other than last-served pointer lp (round-robin).
REQ-022 ISSUE lasts exactly one cycle: gnt[owner]=1 and mul_start=1; next state WAIT; wait counter cleared to 0.
REQ-023 WAIT, mul_done=1: res_p <= mul_p, res_flags <= mul_flags, res_err <= 0; next state RESP.
REQ-024 WAIT, mul_done=0: counter increments; when counter = TIMEOUT-1: res_p <= 0, res_flags <= 0, res_err <= 1; next state RESP.
REQ-025 mul_done and timeout in the same cycle: mul_done wins, res_err=0.
REQ-026 RESP lasts exactly one cycle: done[owner]=1; lp <= owner; next state IDLE.
REQ-027 mul_done outside WAIT is ignored; result registers unchanged.
REQ-028 res_p/res_flags/res_err hold their values until the next capture, including across idle periods.
REQ-029 mul_a/mul_b hold their values from capture until the next IDLE->ISSUE transition.
REQ-030 Latency: req sampled in IDLE at edge N -> gnt and mul_start during cycle N+1; mul_done sampled at edge M -> done[owner] and valid results during cycle M+1.
REQ-031 A req still high during RESP is serviced as a new request from the following IDLE cycle (minimum one IDLE cycle between operations).
REQ-032 gnt0/gnt1 and done0/done1 are mutually exclusive; at most one is high in any cycle.

Reset
REQ-033 While rst is high, regardless of clk: state IDLE; lp=1 (requester 0 wins the first tie); owner=0; counter=0.
REQ-034 While rst is high, all outputs are 0, including res_p, res_flags, res_err, mul_a and mul_b.
REQ-035 rst asserted mid-operation (ISSUE, WAIT or RESP) aborts the operation with no done pulse.
REQ-036 After rst deasserts, a mul_done arriving late is ignored.

Verification
REQ-037 Single op: req0=1, a0=0x40000000, b0=0x40400000; mul_done 5 cycles after mul_start with mul_p=0x40C00000 -> one gnt0 pulse, one done0 pulse, res_p=0x40C00000, res_err=0.
REQ-038 Tie after reset: req0=req1=1 held -> grants alternate gnt0, gnt1, gnt0, gnt1 over four operations; each gnt is followed by a matching done.
REQ-039 Timeout: TIMEOUT=8, mul_done never asserted -> done pulse 8 cycles after entering WAIT; res_err=1, res_p=0, res_flags=0.
REQ-040 Race: mul_done asserted on the cycle counter=TIMEOUT-1 -> res_err=0, res_p=mul_p.
REQ-041 Spurious mul_done in IDLE, and rst asserted during WAIT -> result registers unchanged by the spurious done; no done pulse; state IDLE; all outputs 0.

Source files
------------

// File: rtl/fpmul_arbiter_if.sv
// ---------------------------------------------------------------------------
// fpmul_arbiter_if
// Bundles the requester-side handshake/operand/result signals and the
// multiplier-side start/operand/product signals of fpmul_arbiter.
//
// Modports
//   slave  : the arbiter (receives requests and multiplier responses,
//            drives grants, completions, results and multiplier commands)
//   master : the environment (requesters plus multiplier)
//
// Signals
//   req0/req1          level requests, held with operands until grant
//   a0/b0/a1/b1        operands of requester 0/1
//   gnt0/gnt1          one-cycle grant pulses
//   done0/done1        one-cycle completion pulses
//   res_p/res_flags    captured product and {OF,UF,NANF,INFF,DNF,ZF}
//   res_err            last operation timed out
//   busy               arbiter not idle
//   mul_start          start pulse to the multiplier
//   mul_a/mul_b        latched operands to the multiplier
//   mul_done           multiplier completion
//   mul_p/mul_flags    multiplier product and flags
// ---------------------------------------------------------------------------
interface fpmul_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req0;
   logic             req1;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic             gnt0;
   logic             gnt1;
   logic             done0;
   logic             done1;
   logic [WIDTH-1:0] res_p;
   logic [5:0]       res_flags;
   logic             res_err;
   logic             busy;
   logic             mul_start;
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic             mul_done;
   logic [WIDTH-1:0] mul_p;
   logic [5:0]       mul_flags;

   modport slave (
      input  req0, req1, a0, b0, a1, b1,
      input  mul_done, mul_p, mul_flags,
      output gnt0, gnt1, done0, done1,
      output res_p, res_flags, res_err, busy,
      output mul_start, mul_a, mul_b
   );

   modport master (
      output req0, req1, a0, b0, a1, b1,
      output mul_done, mul_p, mul_flags,
      input  gnt0, gnt1, done0, done1,
      input  res_p, res_flags, res_err, busy,
      input  mul_start, mul_a, mul_b
   );
endinterface

// File: rtl/fpmul_arbiter.sv
// ---------------------------------------------------------------------------
// fpmul_arbiter
// Shares one floating-point multiplier between two requesters. A request is
// accepted in IDLE (round-robin on a tie), its operands are latched onto the
// multiplier bus, a start pulse is issued, and the arbiter waits for the
// multiplier with a bounded timeout. The product/flags (or an error result
// on timeout) are captured and a completion pulse goes to the owner.
//
// Ports
//   clk   : clock, all state changes on the rising edge
//   rst   : asynchronous active-high reset
//   bus   : fpmul_arbiter_if.slave (requesters + multiplier)
//
// Parameters
//   WIDTH   : operand/result width
//   TIMEOUT : WAIT cycles before abort, 2..255
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no operation; sample requests, pick owner, latch operands
// ISSUE  | one cycle: grant to owner, start pulse to multiplier
// WAIT   | waiting for mul_done, counting toward TIMEOUT
// RESP   | one cycle: done pulse to owner, update last-served pointer
// ---------------------------------------------------------------------------
module fpmul_arbiter #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   fpmul_arbiter_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

   state_t           r_state;
   state_t           w_state_nxt;

   logic             r_owner;
   logic             r_lp;
   logic [7:0]       r_cnt;
   logic [WIDTH-1:0] r_mul_a;
   logic [WIDTH-1:0] r_mul_b;
   logic [WIDTH-1:0] r_res_p;
   logic [5:0]       r_res_flags;
   logic             r_res_err;

   logic             w_req_any;
   logic             w_sel_owner;
   logic             w_cnt_last;

   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_done0;
   logic             w_done1;
   logic             w_mul_start;
   logic             w_busy;

   assign w_req_any  = bus.req0 | bus.req1;
   assign w_cnt_last = (r_cnt == C_CNT_LAST);

   // On a tie the requester that was not served last wins; r_lp resets to 1
   // so requester 0 wins the first tie.
   always_comb begin
      w_sel_owner = 1'b0;
      if (bus.req0 && bus.req1) begin
         w_sel_owner = ~r_lp;
      end else if (bus.req1) begin
         w_sel_owner = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req_any) begin
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (bus.mul_done || w_cnt_last) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath registers: owner, round-robin pointer, wait counter,
   // multiplier operands and captured result.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner     <= 1'b0;
         r_lp        <= 1'b1;
         r_cnt       <= 8'd0;
         r_mul_a     <= '0;
         r_mul_b     <= '0;
         r_res_p     <= '0;
         r_res_flags <= 6'd0;
         r_res_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req_any) begin
                  r_owner <= w_sel_owner;
                  r_mul_a <= w_sel_owner ? bus.a1 : bus.a0;
                  r_mul_b <= w_sel_owner ? bus.b1 : bus.b0;
               end
            end
            S_ISSUE: begin
               r_cnt <= 8'd0;
            end
            S_WAIT: begin
               // A completion in the last counted cycle beats the timeout.
               if (bus.mul_done) begin
                  r_res_p     <= bus.mul_p;
                  r_res_flags <= bus.mul_flags;
                  r_res_err   <= 1'b0;
               end else if (w_cnt_last) begin
                  r_res_p     <= '0;
                  r_res_flags <= 6'd0;
                  r_res_err   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_RESP: begin
               r_lp <= r_owner;
            end
            default: begin
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Output decode (registered state/owner only, no input feed-through)
   // ---------------------------------------------------------------------
   always_comb begin
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      w_done0     = 1'b0;
      w_done1     = 1'b0;
      w_mul_start = 1'b0;
      w_busy      = (r_state != S_IDLE);
      case (r_state)
         S_ISSUE: begin
            w_gnt0      = ~r_owner;
            w_gnt1      = r_owner;
            w_mul_start = 1'b1;
         end
         S_RESP: begin
            w_done0 = ~r_owner;
            w_done1 = r_owner;
         end
         default: begin
         end
      endcase
   end

   assign bus.gnt0      = w_gnt0;
   assign bus.gnt1      = w_gnt1;
   assign bus.done0     = w_done0;
   assign bus.done1     = w_done1;
   assign bus.mul_start = w_mul_start;
   assign bus.busy      = w_busy;
   assign bus.mul_a     = r_mul_a;
   assign bus.mul_b     = r_mul_b;
   assign bus.res_p     = r_res_p;
   assign bus.res_flags = r_res_flags;
   assign bus.res_err   = r_res_err;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpmul_arbiter
// Directed stimulus with a grant/done scoreboard. The stimulus side pushes
// the expected grant (owner, latched operands) and expected completion
// (owner, product, flags, error) into queues; a monitor on the falling edge
// pops and compares whenever a grant or done pulse is presented.
// ---------------------------------------------------------------------------
module tb_fpmul_arbiter;

   localparam int W  = 32;
   localparam int TO = 8;

   typedef struct {
      logic         owner;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } gnt_exp_t;

   typedef struct {
      logic         owner;
      logic [W-1:0] p;
      logic [5:0]   f;
      logic         err;
   } done_exp_t;

   logic clk;
   logic rst;

   fpmul_arbiter_if #(.WIDTH(W)) bus ();

   fpmul_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   gnt_exp_t  q_gnt[$];
   done_exp_t q_done[$];

   int n_checks = 0;
   int n_errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst) begin
         int hot;
         hot = int'(bus.gnt0) + int'(bus.gnt1) + int'(bus.done0) + int'(bus.done1);
         if (hot != 0) chk("pulse_exclusive", 64'(hot), 64'd1);
         if (bus.gnt0 || bus.gnt1) begin
            if (q_gnt.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_gnt: gnt0=%0b gnt1=%0b with none expected at %0t",
                        bus.gnt0, bus.gnt1, $time);
            end else begin
               gnt_exp_t g;
               g = q_gnt.pop_front();
               chk("gnt_owner", 64'(bus.gnt1), 64'(g.owner));
               chk("gnt_mul_a", 64'(bus.mul_a), 64'(g.a));
               chk("gnt_mul_b", 64'(bus.mul_b), 64'(g.b));
               chk("gnt_mul_start", 64'(bus.mul_start), 64'd1);
            end
         end
         if (bus.done0 || bus.done1) begin
            if (q_done.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_done: done0=%0b done1=%0b with none expected at %0t",
                        bus.done0, bus.done1, $time);
            end else begin
               done_exp_t d;
               d = q_done.pop_front();
               chk("done_owner", 64'(bus.done1), 64'(d.owner));
               chk("done_res_p", 64'(bus.res_p), 64'(d.p));
               chk("done_res_flags", 64'(bus.res_flags), 64'(d.f));
               chk("done_res_err", 64'(bus.res_err), 64'(d.err));
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for the ISSUE cycle; returns the number of edges it took.
   task automatic wait_start(output int cycles);
      cycles = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         cycles++;
         if (bus.mul_start) return;
      end
      n_checks++;
      n_errors++;
      $display("FAIL wait_start: no mul_start within 50 cycles at %0t", $time);
      cycles = -1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50; i++) begin
         if (!bus.busy) return;
         tick();
      end
      n_checks++;
      n_errors++;
      $display("FAIL wait_idle: busy still 1 after 50 cycles at %0t", $time);
   endtask

   // Called at the ISSUE sample point; answers after dly cycles.
   task automatic respond(input int dly, input logic owner,
                          input logic [W-1:0] p, input logic [5:0] f);
      repeat (dly) tick();
      bus.mul_done  = 1'b1;
      bus.mul_p     = p;
      bus.mul_flags = f;
      q_done.push_back('{owner: owner, p: p, f: f, err: 1'b0});
      tick();
      bus.mul_done = 1'b0;
      chk("done_latency", 64'(owner ? bus.done1 : bus.done0), 64'd1);
   endtask

   task automatic check_all_zero(input string tag);
      logic [W*3+6+9-1:0] v;
      v = {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.mul_start,
           bus.res_err, bus.res_flags, bus.res_p, bus.mul_a, bus.mul_b, 2'b00};
      n_checks++;
      if (v != '0) begin
         n_errors++;
         $display("FAIL %s: outputs not all zero (res_p=0x%0h mul_a=0x%0h mul_b=0x%0h busy=%0b err=%0b flags=0x%0h) at %0t",
                  tag, bus.res_p, bus.mul_a, bus.mul_b, bus.busy, bus.res_err, bus.res_flags, $time);
      end
   endtask

   // ---------------- directed sequence ----------------
   logic [W-1:0] tie_p [4];
   logic [5:0]   tie_f [4];

   initial begin
      int cyc;
      logic [W-1:0] race_p;

      tie_p[0] = 32'h40C00000; tie_f[0] = 6'b000000;
      tie_p[1] = 32'h41000000; tie_f[1] = 6'b000001;
      tie_p[2] = 32'h3F800000; tie_f[2] = 6'b000010;
      tie_p[3] = 32'h7F800000; tie_f[3] = 6'b000100;

      rst = 1'b1;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
      bus.mul_done = 1'b0; bus.mul_p = '0; bus.mul_flags = '0;
      repeat (3) tick();
      check_all_zero("reset_outputs");
      rst = 1'b0;
      tick();

      // Single operation from requester 0: 2.0 * 3.0 = 6.0
      bus.a0 = 32'h40000000; bus.b0 = 32'h40400000; bus.req0 = 1'b1;
      q_gnt.push_back('{owner: 1'b0, a: 32'h40000000, b: 32'h40400000});
      wait_start(cyc);
      chk("gnt_latency", 64'(cyc), 64'd1);
      bus.req0 = 1'b0;
      respond(5, 1'b0, 32'h40C00000, 6'b000000);
      wait_idle();
      chk("single_res_p_held", 64'(bus.res_p), 64'h40C00000);

      // Tie after reset: grants alternate 0,1,0,1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.a0 = 32'h3FC00000; bus.b0 = 32'h40800000;
      bus.a1 = 32'hC0000000; bus.b1 = 32'h3F000000;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) q_gnt.push_back('{owner: 1'b0, a: 32'h3FC00000, b: 32'h40800000});
         else            q_gnt.push_back('{owner: 1'b1, a: 32'hC0000000, b: 32'h3F000000});
      end
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_start(cyc);
         // from the RESP sample point: one IDLE cycle, then ISSUE
         if (k > 0) chk("rr_idle_gap", 64'(cyc), 64'd2);
         if (k == 3) begin
            bus.req0 = 1'b0; bus.req1 = 1'b0;
         end
         respond(2, 1'(k % 2), tie_p[k], tie_f[k]);
      end
      wait_idle();

      // Timeout from requester 1, multiplier never answers
      bus.a1 = 32'h12345678; bus.b1 = 32'h9ABCDEF0; bus.req1 = 1'b1;
      q_gnt.push_back('{owner: 1'b1, a: 32'h12345678, b: 32'h9ABCDEF0});
      q_done.push_back('{owner: 1'b1, p: '0, f: 6'd0, err: 1'b1});
      wait_start(cyc);
      bus.req1 = 1'b0;
      cyc = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 4) chk("res_hold_in_wait", 64'(bus.res_p), 64'h7F800000);
         if (bus.done1) begin
            cyc = i;
            break;
         end
      end
      // WAIT entered one edge after ISSUE, done 8 cycles after that
      chk("timeout_latency", 64'(cyc), 64'(TO + 1));
      wait_idle();
      chk("timeout_err_held", 64'(bus.res_err), 64'd1);

      // Race: mul_done in the cycle where the counter reaches TIMEOUT-1
      race_p = 32'h42280000;
      bus.a0 = 32'h40A00000; bus.b0 = 32'h41000000; bus.req0 = 1'b1;
      q_gnt.push_back('{owner: 1'b0, a: 32'h40A00000, b: 32'h41000000});
      wait_start(cyc);
      bus.req0 = 1'b0;
      respond(TO, 1'b0, race_p, 6'b100000);
      wait_idle();

      // Spurious mul_done in IDLE leaves results alone
      bus.mul_done = 1'b1; bus.mul_p = 32'hDEADBEEF; bus.mul_flags = 6'h3F;
      tick();
      bus.mul_done = 1'b0;
      tick();
      chk("spurious_res_p", 64'(bus.res_p), 64'(race_p));
      chk("spurious_res_flags", 64'(bus.res_flags), 64'b100000);
      chk("spurious_res_err", 64'(bus.res_err), 64'd0);
      chk("spurious_busy", 64'(bus.busy), 64'd0);

      // Reset during WAIT aborts silently; a late mul_done is ignored
      bus.a1 = 32'h11111111; bus.b1 = 32'h22222222; bus.req1 = 1'b1;
      q_gnt.push_back('{owner: 1'b1, a: 32'h11111111, b: 32'h22222222});
      wait_start(cyc);
      bus.req1 = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      #1;
      check_all_zero("async_reset_in_wait");
      repeat (2) tick();
      rst = 1'b0;
      tick();
      bus.mul_done = 1'b1; bus.mul_p = 32'hCAFEF00D; bus.mul_flags = 6'h2A;
      tick();
      bus.mul_done = 1'b0;
      repeat (3) tick();
      check_all_zero("after_late_done");

      chk("gnt_queue_empty", 64'(q_gnt.size()), 64'd0);
      chk("done_queue_empty", 64'(q_done.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
